// File: rtl/solar_pkg.sv
// Shared types and default constants for the multi-panel solar tracker.
package solar_pkg;

  // Per-channel tracking state, exported on state_o as 2-bit fields
  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_NIGHT = 2'b01,
    S_DAY   = 2'b10,
    S_STOW  = 2'b11
  } state_t;

  localparam int DEF_N_PANELS    = 4;
  localparam int DEF_ANGLE_W     = 16;     // 2^ANGLE_W is one full turn
  localparam int DEF_ANGLE_INIT  = 16384;  // quarter turn
  localparam int DEF_DELTA       = 2447;   // ~0.2346 rad per tick
  localparam int DEF_SUN_W       = 5;
  localparam int DEF_POWER_W     = 8;
  localparam int DEF_POWER_CONST = 120;

endpackage

// File: rtl/solar_channel.sv
// One tracking channel: FSM, angle register and power register.
// Advances only on tick; an accepted write replaces the angle and nothing else.
module solar_channel
  import solar_pkg::*;
#(
  parameter int ANGLE_W     = DEF_ANGLE_W,
  parameter int ANGLE_INIT  = DEF_ANGLE_INIT,
  parameter int DELTA       = DEF_DELTA,
  parameter int POWER_W     = DEF_POWER_W,
  parameter int POWER_CONST = DEF_POWER_CONST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               en,
  input  logic               daylight,
  input  logic               wr,
  input  logic [ANGLE_W-1:0] wr_angle,
  output logic [ANGLE_W-1:0] angle,
  output logic [POWER_W-1:0] power,
  output state_t             state
);

  localparam logic [ANGLE_W-1:0] INIT_V  = ANGLE_W'(ANGLE_INIT);
  localparam logic [ANGLE_W-1:0] DELTA_V = ANGLE_W'(DELTA);
  // Upper edge of the "close enough to zero" window on the wrapped side
  localparam logic [ANGLE_W-1:0] STOW_HI = ANGLE_W'((1 << ANGLE_W) - DELTA);
  localparam logic [POWER_W-1:0] PWR_V   = POWER_W'(POWER_CONST);

  logic near_zero;
  assign near_zero = (angle <= DELTA_V) || (angle >= STOW_HI);

  // Channel FSM; a transition tick performs the leaving state's action,
  // except that the tick entering STOW does not move the panel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_OFF;
      angle <= INIT_V;
      power <= '0;
    end else if (wr) begin
      angle <= wr_angle;
    end else if (tick) begin
      case (state)
        S_OFF: begin
          power <= '0;
          if (en) state <= S_NIGHT;
        end
        S_NIGHT: begin
          power <= '0;
          if (!en) begin
            state <= S_STOW;
          end else begin
            angle <= angle + DELTA_V;
            if (daylight) state <= S_DAY;
          end
        end
        S_DAY: begin
          if (!en) begin
            state <= S_STOW;
            power <= '0;
          end else begin
            angle <= angle - DELTA_V;
            power <= PWR_V;
            if (!daylight) state <= S_NIGHT;
          end
        end
        S_STOW: begin
          power <= '0;
          if (near_zero) begin
            angle <= '0;
            state <= S_OFF;
          end else if (!angle[ANGLE_W-1]) begin
            angle <= angle - DELTA_V;
          end else begin
            angle <= angle + DELTA_V;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

endmodule

// File: rtl/solar_array.sv
// N-channel solar tracker: shared sun counter, write decode, power adder
// and the update-pulse pipeline around an array of solar_channel instances.
module solar_array
  import solar_pkg::*;
#(
  parameter int N_PANELS    = DEF_N_PANELS,
  parameter int ANGLE_W     = DEF_ANGLE_W,
  parameter int ANGLE_INIT  = DEF_ANGLE_INIT,
  parameter int DELTA       = DEF_DELTA,
  parameter int SUN_W       = DEF_SUN_W,
  parameter int POWER_W     = DEF_POWER_W,
  parameter int POWER_CONST = DEF_POWER_CONST
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tick,
  input  logic [N_PANELS-1:0]                    en,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [$clog2(N_PANELS)-1:0]            wr_chan,
  input  logic [ANGLE_W-1:0]                     wr_angle,
  output logic [N_PANELS*ANGLE_W-1:0]            angle_o,
  output logic [N_PANELS*POWER_W-1:0]            power_o,
  output logic [N_PANELS*2-1:0]                  state_o,
  output logic [POWER_W+$clog2(N_PANELS)-1:0]    total_power,
  output logic [SUN_W-1:0]                       sun_o
  ,output logic                                  upd
);

  localparam int TP_W   = POWER_W + $clog2(N_PANELS);
  localparam int STAGES = 1;

  logic [N_PANELS-1:0][ANGLE_W-1:0] angle;
  logic [N_PANELS-1:0][POWER_W-1:0] power;
  logic [N_PANELS-1:0][1:0]         state;
  logic [SUN_W-1:0]                 sun;
  logic                             daylight;
  logic                             wr_fire;
  logic [TP_W-1:0]                  psum;
  logic [STAGES:0]                  vld_pipe;

  // Writes are refused in tick cycles so a write and a tick never share an edge
  assign wr_ready = rst && !tick;
  assign wr_fire  = wr_valid && wr_ready;
  assign daylight = sun[SUN_W-1];

  assign angle_o = angle;
  assign power_o = power;
  assign state_o = state;
  assign sun_o   = sun;
  assign upd     = vld_pipe[STAGES];

  // Sun period counter, advancing once per tick
  always_ff @(posedge clk) begin
    if (!rst)      sun <= '0;
    else if (tick) sun <= sun + 1'b1;
  end

  for (genvar i = 0; i < N_PANELS; i++) begin : g_chan
    state_t st;
    assign state[i] = st;

    solar_channel #(
      .ANGLE_W    (ANGLE_W),
      .ANGLE_INIT (ANGLE_INIT),
      .DELTA      (DELTA),
      .POWER_W    (POWER_W),
      .POWER_CONST(POWER_CONST)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .en      (en[i]),
      .daylight(daylight),
      .wr      (wr_fire && (wr_chan == ($clog2(N_PANELS))'(i))),
      .wr_angle(wr_angle),
      .angle   (angle[i]),
      .power   (power[i]),
      .state   (st)
    );
  end

  // Zero-extended sum of all channel power fields
  always_comb begin
    psum = '0;
    for (int i = 0; i < N_PANELS; i++) psum = psum + TP_W'(power[i]);
  end

  // Registered total, one edge behind the power registers
  always_ff @(posedge clk) begin
    if (!rst) total_power <= '0;
    else      total_power <= psum;
  end

  // upd trails the tick by one edge so it lines up with the fresh total
  always_ff @(posedge clk) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:0], tick};
  end

endmodule

// File: tb/tb_solar_array.sv
// Self-checking bench for solar_array: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_solar_array;

  localparam int NP    = 4;
  localparam int AW    = 16;
  localparam int PW    = 8;
  localparam int SW    = 5;
  localparam int TW    = 10;
  localparam int DELTA = 2447;
  localparam int TURN  = 65536;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tick = 1'b0;
  logic [NP-1:0]   en = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [1:0]      wr_chan = '0;
  logic [AW-1:0]   wr_angle = '0;
  logic [NP*AW-1:0] angle_o;
  logic [NP*PW-1:0] power_o;
  logic [NP*2-1:0]  state_o;
  logic [TW-1:0]    total_power;
  logic [SW-1:0]    sun_o;
  logic             upd;

  solar_array dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_angle(wr_angle),
    .angle_o(angle_o), .power_o(power_o), .state_o(state_o),
    .total_power(total_power), .sun_o(sun_o), .upd(upd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Reference model: 0=off 1=night 2=day 3=stow
  int m_state [NP];
  int m_angle [NP];
  int m_power [NP];
  int m_sun, m_total, m_upd, m_tick_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ang(input int c);
    return int'(angle_o[c*AW +: AW]);
  endfunction
  function automatic int st(input int c);
    return int'(state_o[c*2 +: 2]);
  endfunction
  function automatic int pwr(input int c);
    return int'(power_o[c*PW +: PW]);
  endfunction

  // Advance one channel by one tick following the tracking rules
  task automatic model_chan(input int c, input bit e, input bit day);
    case (m_state[c])
      0: begin
        m_power[c] = 0;
        if (e) m_state[c] = 1;
      end
      1: begin
        m_power[c] = 0;
        if (!e) m_state[c] = 3;
        else begin
          m_angle[c] = (m_angle[c] + DELTA) % TURN;
          if (day) m_state[c] = 2;
        end
      end
      2: begin
        if (!e) begin
          m_state[c] = 3;
          m_power[c] = 0;
        end else begin
          m_angle[c] = (m_angle[c] - DELTA + TURN) % TURN;
          m_power[c] = 120;
          if (!day) m_state[c] = 1;
        end
      end
      default: begin
        m_power[c] = 0;
        if (m_angle[c] <= DELTA || m_angle[c] >= TURN - DELTA) begin
          m_angle[c] = 0;
          m_state[c] = 0;
        end else if (m_angle[c] < TURN / 2) m_angle[c] = m_angle[c] - DELTA;
        else m_angle[c] = (m_angle[c] + DELTA) % TURN;
      end
    endcase
  endtask

  // Model update on each rising edge from the inputs held over that edge
  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NP; c++) begin
        m_state[c] = 0;
        m_angle[c] = 16384;
        m_power[c] = 0;
      end
      m_sun = 0; m_total = 0; m_upd = 0; m_tick_prev = 0;
    end else begin
      m_total = 0;
      for (int c = 0; c < NP; c++) m_total += m_power[c];
      m_upd       = m_tick_prev;
      m_tick_prev = int'(tick);
      if (wr_valid && !tick) begin
        m_angle[wr_chan] = int'(wr_angle);
      end else if (tick) begin
        bit day;
        day   = (m_sun >= (1 << (SW - 1)));
        m_sun = (m_sun + 1) % (1 << SW);
        for (int c = 0; c < NP; c++) model_chan(c, en[c], day);
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < NP; c++) begin
        chk($sformatf("angle[%0d]", c), 64'(ang(c)), 64'(m_angle[c]));
        chk($sformatf("state[%0d]", c), 64'(st(c)), 64'(m_state[c]));
        chk($sformatf("power[%0d]", c), 64'(pwr(c)), 64'(m_power[c]));
      end
      chk("sun", 64'(sun_o), 64'(m_sun));
      chk("total_power", 64'(total_power), 64'(m_total));
      chk("upd", 64'(upd), 64'(m_upd));
      chk("wr_ready", 64'(wr_ready), 64'(rst && !tick));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic one_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    // Reset
    cyc();
    chk_on = 1;
    cyc();
    for (int c = 0; c < NP; c++) begin
      chk("rst_angle", 64'(ang(c)), 64'd16384);
      chk("rst_state", 64'(st(c)), 64'd0);
    end
    chk("rst_sun", 64'(sun_o), 64'd0);
    chk("rst_total", 64'(total_power), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_upd", 64'(upd), 64'd0);
    rst = 1'b1;
    cyc();

    // Enable channel 0
    en = 4'b0001;
    one_tick();
    chk("en_state0", 64'(st(0)), 64'd1);
    chk("en_angle0", 64'(ang(0)), 64'd16384);
    cyc();
    chk("en_upd1", 64'(upd), 64'd1);
    one_tick();
    chk("en_angle0_step", 64'(ang(0)), 64'd18831);
    chk("en_sun2", 64'(sun_o), 64'd2);
    cyc();
    chk("en_upd2", 64'(upd), 64'd1);
    cyc();
    chk("en_upd_low", 64'(upd), 64'd0);

    // All channels into DAY
    en = 4'b1111;
    tick = 1'b1;
    repeat (14) cyc();
    chk("day_sun16", 64'(sun_o), 64'd16);
    cyc();
    for (int c = 0; c < NP; c++) chk("day_state", 64'(st(c)), 64'd2);
    cyc();
    tick = 1'b0;
    for (int c = 0; c < NP; c++) chk("day_power", 64'(pwr(c)), 64'd120);
    cyc();
    chk("day_total", 64'(total_power), 64'd480);

    // Back to NIGHT, then wrap channel 1 past the top of the turn
    tick = 1'b1;
    repeat (15) cyc();
    tick = 1'b0;
    chk("wrap_sun", 64'(sun_o), 64'd1);
    chk("wrap_state1", 64'(st(1)), 64'd1);
    wr_valid = 1'b1; wr_chan = 2'd1; wr_angle = 16'hFFFF;
    cyc();
    wr_valid = 1'b0;
    chk("wr_angle1", 64'(ang(1)), 64'd65535);
    one_tick();
    chk("wrap_angle1", 64'(ang(1)), 64'd2446);

    // Stow channel 2 from DAY at 5000
    tick = 1'b1;
    repeat (16) cyc();
    tick = 1'b0;
    chk("stow_pre_state2", 64'(st(2)), 64'd2);
    chk("stow_pre_power2", 64'(pwr(2)), 64'd120);
    wr_valid = 1'b1; wr_chan = 2'd2; wr_angle = 16'd5000;
    cyc();
    wr_valid = 1'b0;
    en = 4'b1011;
    one_tick();
    chk("stow_state2", 64'(st(2)), 64'd3);
    chk("stow_angle2", 64'(ang(2)), 64'd5000);
    chk("stow_power2", 64'(pwr(2)), 64'd0);
    one_tick();
    chk("stow_a1", 64'(ang(2)), 64'd2553);
    one_tick();
    chk("stow_a2", 64'(ang(2)), 64'd106);
    one_tick();
    chk("stow_a3", 64'(ang(2)), 64'd0);
    chk("stow_off", 64'(st(2)), 64'd0);

    // Write held across a tick cycle
    wr_valid = 1'b1; wr_chan = 2'd0; wr_angle = 16'd1234; tick = 1'b1;
    #1;
    chk("conf_ready_low", 64'(wr_ready), 64'd0);
    cyc();
    tick = 1'b0;
    #1;
    chk("conf_ready_high", 64'(wr_ready), 64'd1);
    cyc();
    wr_valid = 1'b0;
    chk("conf_wr_landed", 64'(ang(0)), 64'd1234);

    // Reset in the middle of stowing
    en = 4'b0011;
    one_tick();
    chk("mid_stow_state3", 64'(st(3)), 64'd3);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mid_stow_angle3", 64'(ang(3)), 64'd16384);
    chk("mid_stow_off3", 64'(st(3)), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst  = ($urandom_range(0, 299) != 0);
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_chan  = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       wr_angle = 16'($urandom_range(0, 2 * DELTA));
        1:       wr_angle = 16'(TURN - 1 - $urandom_range(0, 2 * DELTA));
        default: wr_angle = 16'($urandom);
      endcase
    end
    rst = 1'b1; tick = 1'b0; wr_valid = 1'b0;
    cyc();
    cyc();
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/solar_array.md
# solar_array

Multi-panel successor to the single solar component: N independent tracking channels share one sun-period counter, and each channel runs its own tracking FSM with fixed-point angles instead of reals. Adds a stow mode that parks a panel at angle 0 when it is disabled, and an angle-write port with a ready/valid handshake. Sits under the control module beside the airflow and thrusters blocks. It advances only on the server tick strobe, and its `upd` pulse tells the host reporter to emit an update line.

## Interface
- `N_PANELS`, 4: number of channels.
- `ANGLE_W`, 16: angle width; 2^ANGLE_W equals one full turn.
- `ANGLE_INIT`, 16384: reset angle (quarter turn).
- `DELTA`, 2447: per-tick step (about 0.2346 rad).
- `SUN_W`, 5: sun counter width; period is 2^SUN_W ticks.
- `POWER_W`, 8: per-channel power width.
- `POWER_CONST`, 120: power reported in DAY.
- `clk`, in, 1: the single clock, rising edge.
- `rst`, in, 1: **synchronous, active-low** reset.
- `tick`, in, 1: single-cycle advance strobe, derived from the server tick.
- `en`, in, N_PANELS: per-channel online enable.
- `wr_valid`, in, 1: angle-write request.
- `wr_ready`, out, 1: write accepted in any cycle where `wr_valid && wr_ready`.
- `wr_chan`, in, $clog2(N_PANELS): target channel.
- `wr_angle`, in, ANGLE_W: new angle.
- `angle_o`, out, N_PANELS*ANGLE_W: packed per-channel angles, channel 0 in the LSBs.
- `power_o`, out, N_PANELS*POWER_W: packed per-channel power.
- `state_o`, out, N_PANELS*2: packed per-channel FSM state.
- `total_power`, out, POWER_W+$clog2(N_PANELS): sum of all `power_o` fields.
- `sun_o`, out, SUN_W: sun counter value.
- `upd`, out, 1: one-cycle pulse after each processed tick.

## Operation
- **Sun counter.** Increments mod 2^SUN_W on each tick. `daylight` is `sun_o[SUN_W-1]`, taken from the value before the increment.
- **Channel states.** Each channel has four states, checked in the order below on every tick.
  - OFF (00): power 0; angle holds. `en` goes to NIGHT.
  - NIGHT (01): `!en` goes to STOW. Otherwise the angle steps +DELTA, power is 0, and `daylight` goes to DAY.
  - DAY (10): `!en` goes to STOW. Otherwise the angle steps −DELTA, power is POWER_CONST, and `!daylight` goes to NIGHT.
  - STOW (11): power 0. `en` is ignored until stowing completes.
- **State entry.** A transition tick applies the action of the state being left, except that entering STOW applies no motion.
- **Stowing.** On each tick in STOW:
  - If angle ≤ DELTA or angle ≥ 2^ANGLE_W − DELTA: angle becomes 0 and the channel goes to OFF.
  - Otherwise, if angle MSB = 0, subtract DELTA; else add DELTA.
- **Angle arithmetic.** Unsigned mod 2^ANGLE_W; natural wrap in both directions, no saturation.
- **Total power.** Zero-extended sum of `power_o`, registered.
- **Write port.**
  - `wr_ready` = `rst && !tick`; it drops combinationally in tick cycles.
  - An accepted write overwrites `angle[wr_chan]` only; state and power are unchanged.
  - Writes are legal in every state, including STOW, where stowing resumes from the new angle.
- **Reset.** Values while `rst` = 0:
  - All channels OFF; every angle = ANGLE_INIT; power 0.
  - `total_power` 0, `sun_o` 0, `upd` 0, `wr_ready` 0.
  - A tick asserted during reset is dropped.
  - Reset mid-STOW, or in any state, aborts immediately.

## Timing
- Tick sampled at edge k:
  - state, angle, power and `sun_o` update at edge k;
  - `total_power` updates at edge k+1;
  - `upd` is high for the cycle between edges k+1 and k+2, so `total_power` is consistent while `upd` = 1.
- Back-to-back ticks, one per cycle, are legal. `upd` then stays high continuously, and each cycle reflects the previous tick.
- A write accepted at edge k is visible on `angle_o` after edge k.
- Tick and write are never applied at the same edge, because `wr_ready` is low in tick cycles.

## Structure
- Package `solar_pkg`:
  - state encodings `S_OFF`, `S_NIGHT`, `S_DAY`, `S_STOW`;
  - a 2-bit state typedef;
  - the default angle constants.
- Sub-module `solar_channel`: one channel's FSM, angle register and power register, with inputs `tick`, `en`, `daylight` and a write strobe. It is instantiated N_PANELS times by a generate loop.
- The top level holds the sun counter, the write decode, the adder tree and the `upd` pipeline.

## Test plan
All scenarios use the default parameters.
- **Reset.** `rst` = 0 for 2 cycles → all `angle_o` fields 16384, `state_o` all 00, `sun_o` 0, `total_power` 0, `wr_ready` 0, `upd` 0.
- **Enable.** `en` = 0001, tick → ch0 goes to NIGHT with angle 16384. Second tick → ch0 angle 18831, `sun_o` 2, `upd` pulses 1 cycle after each tick.
- **Day, all channels.** `en` = 1111, ticks until `sun_o` = 16, then one more tick → all channels DAY. `power_o` fields 120; `total_power` 480 one cycle later.
- **Wrap.** Write ch1 = 65535 in NIGHT with `daylight` low, then tick → ch1 angle 2446.
- **Stow.** Ch2 in DAY at angle 5000, drop `en[2]`, tick → STOW with angle 5000 and power 0. Following ticks → angle 2553, then 106, then 0 with state OFF.
- **Conflicts.**
  - `wr_valid` held on the same cycle as `tick` → `wr_ready` 0; the write lands the next cycle.
  - `rst` = 0 for one cycle mid-STOW → angle 16384, state OFF.
